ps2_rx_deserializer: RTL and testbench

Receive-only PS/2 link layer. Synchronises and glitch-filters the raw PS2_CLK/PS2_DAT lines, deserialises 11-bit device-to-host frames (start, 8 data LSB-first, odd parity, stop), and presents each good byte as `received_data` with a one-cycle `received_data_en` strobe. It sits directly upstream of the keyboard scan-code decoder and drives that decoder's `received_data`/`received_data_en` inputs. It also flags bad frames separately.

---
 rtl/ps2_rx_deserializer.sv | 178 +++++++++++++++++
 tb/tb_ps2_rx_deserializer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_rx_deserializer.sv
`default_nettype none
// ============================================================================
//  Module   : ps2_rx_deserializer
//  Purpose  : Receive-only PS/2 link layer. Synchronises and glitch-filters
//             the raw PS2_CLK / PS2_DAT lines, deserialises 11-bit
//             device-to-host frames (start, 8 data LSB-first, odd parity,
//             stop) and presents each good byte with a one-cycle strobe.
//             Bad frames are reported on separate one-cycle error strobes.
//  Ports    : CLOCK_50         in   system clock (single domain)
//             reset            in   asynchronous active-high reset
//             PS2_CLK          in   raw PS/2 clock line (asynchronous)
//             PS2_DAT          in   raw PS/2 data line (asynchronous)
//             received_data    out  last correctly received byte
//             received_data_en out  one-cycle strobe, received_data is new
//             parity_error     out  one-cycle strobe, parity mismatch
//             frame_error      out  one-cycle strobe, bad stop bit / timeout
//  Revision : 1.0  initial release
// ============================================================================
module ps2_rx_deserializer #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       PS2_CLK,
    input  logic       PS2_DAT,
    output logic [7:0] received_data,
    output logic       received_data_en,
    output logic       parity_error,
    output logic       frame_error
);

    localparam int FCW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [FCW-1:0] C_FILT_LAST = FCW'(FILTER_LEN - 1);
    localparam logic [TCW-1:0] C_TO_LAST   = TCW'(TIMEOUT_CYCLES - 1);
    localparam logic [TCW-1:0] C_TO_ONE    = TCW'(1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DATA   = 2'd1,
        S_PARITY = 2'd2,
        S_STOP   = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Two-flop synchronisers; idle line level is 1.
    // ------------------------------------------------------------------
    logic r_clk_s1, r_clk_s2;
    logic r_dat_s1, r_dat_s2;

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_clk_s1 <= 1'b1;
            r_clk_s2 <= 1'b1;
            r_dat_s1 <= 1'b1;
            r_dat_s2 <= 1'b1;
        end else begin
            r_clk_s1 <= PS2_CLK;
            r_clk_s2 <= r_clk_s1;
            r_dat_s1 <= PS2_DAT;
            r_dat_s2 <= r_dat_s1;
        end
    end

    // ------------------------------------------------------------------
    // Clock glitch filter. r_filt_cnt counts consecutive samples in which
    // the synchronised clock disagrees with the filtered level; on the
    // FILTER_LEN-th such sample the filtered level flips. r_fall is a
    // registered single-cycle marker of a filtered 1->0 transition.
    // ------------------------------------------------------------------
    logic           r_filt_clk;
    logic [FCW-1:0] r_filt_cnt;
    logic           r_fall;

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_filt_clk <= 1'b1;
            r_filt_cnt <= '0;
            r_fall     <= 1'b0;
        end else begin
            r_fall <= 1'b0;
            if (r_clk_s2 == r_filt_clk) begin
                r_filt_cnt <= '0;
            end else if (r_filt_cnt == C_FILT_LAST) begin
                r_filt_clk <= r_clk_s2;
                r_filt_cnt <= '0;
                r_fall     <= ~r_clk_s2;
            end else begin
                r_filt_cnt <= r_filt_cnt + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Frame state machine with timeout and registered strobes.
    // The timeout counter holds the number of cycles since the last
    // filtered falling edge; it is loaded with 1 when that edge is
    // consumed (one cycle after the filtered transition), so the abort
    // lands exactly TIMEOUT_CYCLES cycles after the filtered edge.
    // A falling edge always takes priority over the terminal count.
    // ------------------------------------------------------------------
    state_t         r_state;
    logic [2:0]     r_bit_cnt;
    logic [7:0]     r_shift;
    logic           r_ok;
    logic [TCW-1:0] r_to_cnt;

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_state          <= S_IDLE;
            r_bit_cnt        <= 3'd0;
            r_shift          <= 8'h00;
            r_ok             <= 1'b0;
            r_to_cnt         <= '0;
            received_data    <= 8'h00;
            received_data_en <= 1'b0;
            parity_error     <= 1'b0;
            frame_error      <= 1'b0;
        end else begin
            received_data_en <= 1'b0;
            parity_error     <= 1'b0;
            frame_error      <= 1'b0;

            if (r_state == S_IDLE) begin
                r_to_cnt <= '0;
                // A high data level on a falling edge is not a start bit.
                if (r_fall && !r_dat_s2) begin
                    r_bit_cnt <= 3'd0;
                    r_shift   <= 8'h00;
                    r_to_cnt  <= C_TO_ONE;
                    r_state   <= S_DATA;
                end
            end else if (r_fall) begin
                r_to_cnt <= C_TO_ONE;
                case (r_state)
                    S_DATA: begin
                        r_shift   <= {r_dat_s2, r_shift[7:1]};
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) begin
                            r_state <= S_PARITY;
                        end
                    end
                    S_PARITY: begin
                        r_ok    <= ^{r_shift, r_dat_s2};
                        r_state <= S_STOP;
                    end
                    S_STOP: begin
                        // A bad stop bit is reported as a framing error
                        // regardless of the parity outcome.
                        if (!r_dat_s2) begin
                            frame_error <= 1'b1;
                        end else if (r_ok) begin
                            received_data    <= r_shift;
                            received_data_en <= 1'b1;
                        end else begin
                            parity_error <= 1'b1;
                        end
                        r_to_cnt <= '0;
                        r_state  <= S_IDLE;
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end else if (r_to_cnt == C_TO_LAST) begin
                frame_error <= 1'b1;
                r_to_cnt    <= '0;
                r_state     <= S_IDLE;
            end else begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ps2_rx_deserializer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ps2_rx_deserializer
//  Purpose  : Self-checking directed testbench for ps2_rx_deserializer.
//             Drives PS/2 frames on the pins and checks strobes, data and
//             strobe latency against hand-computed values.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ps2_rx_deserializer;

    localparam int FL   = 8;
    localparam int TO   = 1000;
    localparam int HALF = 200;

    logic       clk     = 1'b0;
    logic       rst     = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_dat = 1'b1;
    logic [7:0] rx_data;
    logic       rx_en;
    logic       par_err;
    logic       frm_err;

    ps2_rx_deserializer #(
        .FILTER_LEN     (FL),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .CLOCK_50         (clk),
        .reset            (rst),
        .PS2_CLK          (ps2_clk),
        .PS2_DAT          (ps2_dat),
        .received_data    (rx_data),
        .received_data_en (rx_en),
        .parity_error     (par_err),
        .frame_error      (frm_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Strobe monitor, sampled on the falling system clock edge.
    int         n_en = 0, n_pe = 0, n_fe = 0, n_multi = 0;
    int         en_cyc = 0, pe_cyc = 0, fe_cyc = 0;
    logic [7:0] en_data = 8'h00;
    logic [7:0] en_q[$];

    always @(negedge clk) begin
        if (rx_en) begin
            n_en++;
            en_cyc  = cyc;
            en_data = rx_data;
            en_q.push_back(rx_data);
        end
        if (par_err) begin
            n_pe++;
            pe_cyc = cyc;
        end
        if (frm_err) begin
            n_fe++;
            fe_cyc = cyc;
        end
        if ((int'(rx_en) + int'(par_err) + int'(frm_err)) > 1) n_multi++;
    end

    int total = 0;
    int bad   = 0;
    int last_fall = 0;

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Send the first nbits bits of {stop, parity, data, start}.
    task automatic send_frame(input logic [7:0] d, input logic p, input logic s,
                              input int nbits);
        logic [10:0] f;
        f = {s, p, d, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_dat = f[i];
            wait_cyc(HALF / 2);
            ps2_clk   = 1'b0;
            last_fall = cyc;
            wait_cyc(HALF);
            ps2_clk = 1'b1;
            wait_cyc(HALF / 2);
        end
    endtask

    task automatic test_reset();
        wait_cyc(3);
        total++; if (rx_data !== 8'h00) begin bad++; $display("FAIL reset_data got=%h exp=00", rx_data); end
        total++; if (rx_en !== 1'b0) begin bad++; $display("FAIL reset_en got=%b exp=0", rx_en); end
        total++; if (par_err !== 1'b0) begin bad++; $display("FAIL reset_pe got=%b exp=0", par_err); end
        total++; if (frm_err !== 1'b0) begin bad++; $display("FAIL reset_fe got=%b exp=0", frm_err); end
        rst = 1'b0;
        wait_cyc(20);
    endtask

    task automatic test_good_frame();
        int e0, p0, f0;
        e0 = n_en; p0 = n_pe; f0 = n_fe;
        send_frame(8'h1C, 1'b0, 1'b1, 11);
        total++; if (n_en - e0 !== 1) begin bad++; $display("FAIL good_en_count got=%0d exp=1", n_en - e0); end
        total++; if (en_data !== 8'h1C) begin bad++; $display("FAIL good_en_data got=%h exp=1c", en_data); end
        total++; if (rx_data !== 8'h1C) begin bad++; $display("FAIL good_data_hold got=%h exp=1c", rx_data); end
        total++; if (en_cyc - last_fall !== FL + 3) begin bad++; $display("FAIL good_latency got=%0d exp=%0d", en_cyc - last_fall, FL + 3); end
        total++; if ((n_pe - p0) + (n_fe - f0) !== 0) begin bad++; $display("FAIL good_no_err got=%0d exp=0", (n_pe - p0) + (n_fe - f0)); end
    endtask

    task automatic test_parity_error();
        int e0, p0, f0;
        e0 = n_en; p0 = n_pe; f0 = n_fe;
        send_frame(8'h1C, 1'b1, 1'b1, 11);
        total++; if (n_pe - p0 !== 1) begin bad++; $display("FAIL par_pe_count got=%0d exp=1", n_pe - p0); end
        total++; if (pe_cyc - last_fall !== FL + 3) begin bad++; $display("FAIL par_latency got=%0d exp=%0d", pe_cyc - last_fall, FL + 3); end
        total++; if ((n_en - e0) + (n_fe - f0) !== 0) begin bad++; $display("FAIL par_other_strobes got=%0d exp=0", (n_en - e0) + (n_fe - f0)); end
        total++; if (rx_data !== 8'h1C) begin bad++; $display("FAIL par_data_hold got=%h exp=1c", rx_data); end
        e0 = n_en;
        send_frame(8'hF0, 1'b1, 1'b1, 11);
        total++; if (n_en - e0 !== 1) begin bad++; $display("FAIL par_next_en got=%0d exp=1", n_en - e0); end
        total++; if (rx_data !== 8'hF0) begin bad++; $display("FAIL par_next_data got=%h exp=f0", rx_data); end
    endtask

    task automatic test_stop_error();
        int e0, p0, f0;
        e0 = n_en; p0 = n_pe; f0 = n_fe;
        send_frame(8'h75, 1'b0, 1'b0, 11);
        total++; if (n_fe - f0 !== 1) begin bad++; $display("FAIL stop_fe_count got=%0d exp=1", n_fe - f0); end
        total++; if (fe_cyc - last_fall !== FL + 3) begin bad++; $display("FAIL stop_latency got=%0d exp=%0d", fe_cyc - last_fall, FL + 3); end
        total++; if ((n_en - e0) + (n_pe - p0) !== 0) begin bad++; $display("FAIL stop_other_strobes got=%0d exp=0", (n_en - e0) + (n_pe - p0)); end
        total++; if (rx_data !== 8'hF0) begin bad++; $display("FAIL stop_data_hold got=%h exp=f0", rx_data); end
        // Stop bit low with bad parity as well: still a framing error only.
        e0 = n_en; p0 = n_pe; f0 = n_fe;
        send_frame(8'h75, 1'b1, 1'b0, 11);
        total++; if (n_fe - f0 !== 1 || n_pe - p0 !== 0 || n_en - e0 !== 0) begin
            bad++; $display("FAIL stop_and_parity fe=%0d pe=%0d en=%0d exp=1/0/0", n_fe - f0, n_pe - p0, n_en - e0);
        end
    endtask

    task automatic test_timeout();
        int e0, p0, f0;
        e0 = n_en; p0 = n_pe; f0 = n_fe;
        send_frame(8'hE0, 1'b0, 1'b1, 4);
        wait_cyc(TO + 50);
        total++; if (n_fe - f0 !== 1) begin bad++; $display("FAIL to_fe_count got=%0d exp=1", n_fe - f0); end
        total++; if (fe_cyc - last_fall !== FL + 2 + TO) begin bad++; $display("FAIL to_latency got=%0d exp=%0d", fe_cyc - last_fall, FL + 2 + TO); end
        total++; if ((n_en - e0) + (n_pe - p0) !== 0) begin bad++; $display("FAIL to_other_strobes got=%0d exp=0", (n_en - e0) + (n_pe - p0)); end
        e0 = n_en;
        send_frame(8'hE0, 1'b0, 1'b1, 11);
        total++; if (n_en - e0 !== 1) begin bad++; $display("FAIL to_next_en got=%0d exp=1", n_en - e0); end
        total++; if (rx_data !== 8'hE0) begin bad++; $display("FAIL to_next_data got=%h exp=e0", rx_data); end
    endtask

    task automatic test_glitch();
        int e0, p0, f0;
        e0 = n_en; p0 = n_pe; f0 = n_fe;
        ps2_dat = 1'b0;
        wait_cyc(50);
        ps2_clk = 1'b0;
        wait_cyc(3);
        ps2_clk = 1'b1;
        wait_cyc(50);
        total++; if ((n_en - e0) + (n_pe - p0) + (n_fe - f0) !== 0) begin bad++; $display("FAIL glitch_strobes got=%0d exp=0", (n_en - e0) + (n_pe - p0) + (n_fe - f0)); end
        // Clean falling edge with DAT high: not a start bit.
        ps2_dat = 1'b1;
        wait_cyc(HALF / 2);
        ps2_clk = 1'b0;
        wait_cyc(HALF);
        ps2_clk = 1'b1;
        wait_cyc(TO + 50);
        total++; if ((n_en - e0) + (n_pe - p0) + (n_fe - f0) !== 0) begin bad++; $display("FAIL spurious_start_strobes got=%0d exp=0", (n_en - e0) + (n_pe - p0) + (n_fe - f0)); end
        // Receiver must still be aligned to frame boundaries.
        send_frame(8'h1C, 1'b0, 1'b1, 11);
        total++; if (n_en - e0 !== 1 || rx_data !== 8'h1C) begin bad++; $display("FAIL glitch_next_frame en=%0d data=%h exp=1/1c", n_en - e0, rx_data); end
    endtask

    task automatic test_back_to_back();
        int e0, p0, f0;
        send_frame(8'h33, 1'b1, 1'b1, 6);
        #2;
        rst = 1'b1;
        #1;
        total++; if (rx_data !== 8'h00) begin bad++; $display("FAIL midreset_data got=%h exp=00", rx_data); end
        wait_cyc(3);
        rst = 1'b0;
        wait_cyc(10);
        en_q.delete();
        e0 = n_en; p0 = n_pe; f0 = n_fe;
        send_frame(8'hE0, 1'b0, 1'b1, 11);
        send_frame(8'hF0, 1'b1, 1'b1, 11);
        send_frame(8'h75, 1'b0, 1'b1, 11);
        total++; if (n_en - e0 !== 3) begin bad++; $display("FAIL burst_en_count got=%0d exp=3", n_en - e0); end
        total++; if ((n_pe - p0) + (n_fe - f0) !== 0) begin bad++; $display("FAIL burst_errors got=%0d exp=0", (n_pe - p0) + (n_fe - f0)); end
        if (en_q.size() == 3) begin
            total++; if (en_q[0] !== 8'hE0) begin bad++; $display("FAIL burst_byte0 got=%h exp=e0", en_q[0]); end
            total++; if (en_q[1] !== 8'hF0) begin bad++; $display("FAIL burst_byte1 got=%h exp=f0", en_q[1]); end
            total++; if (en_q[2] !== 8'h75) begin bad++; $display("FAIL burst_byte2 got=%h exp=75", en_q[2]); end
        end else begin
            total++; bad++; $display("FAIL burst_queue_size got=%0d exp=3", en_q.size());
        end
    endtask

    task automatic test_exclusive();
        total++; if (n_multi !== 0) begin bad++; $display("FAIL strobe_exclusive got=%0d exp=0", n_multi); end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_parity_error();
        test_stop_error();
        test_timeout();
        test_glitch();
        test_back_to_back();
        test_exclusive();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
